dedup_sequencer: RTL and testbench

- Sequenced, area-lean duplicate remover.
- Loads a frame of N elements over a valid/ready stream and stores them in an internal buffer.
- Scans the buffer with a single shared equality comparator, then streams out only first occurrences, in original order.
- Sits between a producer stream and a downstream consumer wherever the fully parallel N² comparator array is too large.

---
 rtl/dedup_if.sv | 23 ++
 rtl/dedup_sequencer.sv | 132 +++++++++++++
 tb/tb_dedup_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dedup_if.sv
// Stream bundle for dedup_sequencer: a valid/ready load channel in, a valid/ready
// unique-element channel out with a frame-end marker.
interface dedup_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/dedup_sequencer.sv
// Sequenced duplicate remover: LOAD a frame of N elements, SCAN it with one shared
// comparator, EMIT first occurrences in order. `DEDUP_STATS_EN adds a scan_cycles port.
module dedup_sequencer #(
  parameter int N     = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  dedup_if.slave                   bus,
  output logic                     busy,
  output logic [$clog2(N+1)-1:0]   unique_cnt,
  output logic [$clog2(N+1)-1:0]   dup_cnt
`ifdef DEDUP_STATS_EN
  ,
  output logic [15:0]              scan_cycles
`endif
);
  localparam int CW = $clog2(N+1);
  localparam int IW = $clog2(N);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mem [N];
  logic [N-1:0]     keep;
  logic [IW-1:0]    wr_idx, si, sj, rd_idx;
  logic [CW-1:0]    dup_run, dup_total;
  logic             in_accept, scan_hit, scan_step_i, later_keep, emit_fire;

  assign bus.in_ready = (state == S_LOAD);
  assign busy         = (state != S_LOAD);
  assign in_accept    = (state == S_LOAD) && bus.in_valid;

  // A disabled keep[j] still burns its cycle so scan latency depends only on match positions.
  assign scan_hit    = keep[sj] && (mem[si] == mem[sj]);
  assign scan_step_i = scan_hit || (sj == si - IW'(1));
  assign dup_total   = dup_run + CW'(scan_hit);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    later_keep = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (IW'(k) > rd_idx && keep[k]) later_keep = 1'b1;
    end
  end

  assign bus.out_valid = (state == S_EMIT) && keep[rd_idx];
  assign bus.out_data  = bus.out_valid ? mem[rd_idx] : '0;
  assign bus.out_last  = bus.out_valid && !later_keep;
  assign emit_fire     = bus.out_valid && bus.out_ready;

  // NOTE: the frame buffer is plain storage with no reset; only control state is reset.
  always_ff @(posedge clk) begin
    if (in_accept) mem[wr_idx] <= bus.in_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_LOAD;
      keep       <= '1;
      wr_idx     <= '0;
      si         <= '0;
      sj         <= '0;
      rd_idx     <= '0;
      dup_run    <= '0;
      unique_cnt <= '0;
      dup_cnt    <= '0;
`ifdef DEDUP_STATS_EN
      scan_cycles <= '0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          if (in_accept) begin
            if (wr_idx == IW'(N-1)) begin
              state   <= S_SCAN;
              si      <= IW'(1);
              sj      <= '0;
              keep    <= '1;
              dup_run <= '0;
`ifdef DEDUP_STATS_EN
              scan_cycles <= '0;
`endif
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end

        S_SCAN: begin
`ifdef DEDUP_STATS_EN
          if (scan_cycles != 16'hFFFF) scan_cycles <= scan_cycles + 16'd1;
`endif
          if (scan_hit) begin
            keep[si] <= 1'b0;
            dup_run  <= dup_total;
          end
          if (scan_step_i) begin
            sj <= '0;
            si <= si + IW'(1);
            if (si == IW'(N-1)) begin
              state      <= S_EMIT;
              rd_idx     <= '0;
              dup_cnt    <= dup_total;
              unique_cnt <= CW'(N) - dup_total;
            end
          end else begin
            sj <= sj + IW'(1);
          end
        end

        S_EMIT: begin
          if (!keep[rd_idx]) begin
            rd_idx <= rd_idx + IW'(1);
          end else if (emit_fire) begin
            if (bus.out_last) begin
              state  <= S_LOAD;
              wr_idx <= '0;
            end else begin
              rd_idx <= rd_idx + IW'(1);
            end
          end
        end

        default: state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_dedup_sequencer.sv
// Scoreboard bench for dedup_sequencer: a reference model computes each frame's unique
// sequence and counts; a negedge monitor compares every output handshake against them.
module tb_dedup_sequencer;
  localparam int N = 8;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic [3:0] unique_cnt, dup_cnt;
`ifdef DEDUP_STATS_EN
  logic [15:0] scan_cycles;
`endif

  dedup_if #(.WIDTH(W)) bus ();

  dedup_sequencer #(.N(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .unique_cnt (unique_cnt),
    .dup_cnt    (dup_cnt)
`ifdef DEDUP_STATS_EN
    ,
    .scan_cycles(scan_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int frames_done = 0;
  int stall_seen  = 0;
  exp_t exp_q[$];
  logic [W-1:0] frame [N];
  int exp_unique, exp_dup, exp_scan;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: a value is output iff it has not appeared earlier in the frame. The scan
  // spends first_occurrence+1 cycles on a duplicate at index i, and i cycles on a new value.
  task automatic model_push();
    logic [W-1:0] uq[$];
    int first;
    uq.delete();
    exp_scan = 0;
    for (int i = 0; i < N; i++) begin
      first = -1;
      for (int m = 0; m < i; m++) if (first < 0 && frame[m] == frame[i]) first = m;
      if (first < 0) begin
        uq.push_back(frame[i]);
        exp_scan += i;
      end else begin
        exp_scan += first + 1;
      end
    end
    exp_unique = uq.size();
    exp_dup    = N - uq.size();
    for (int k = 0; k < uq.size(); k++) exp_q.push_back('{data: uq[k], last: (k == uq.size() - 1)});
  endtask

  // Monitor: compares each output handshake and the hold-under-backpressure rule.
  logic hold_prev = 1'b0;
  logic [W-1:0] hold_data;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check("hold_data", {24'd0, bus.out_data}, {24'd0, hold_data});
      end
      if (bus.out_valid && !bus.out_ready && bus.out_data == 8'd1) stall_seen++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h, expected no output", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {24'd0, bus.out_data}, {24'd0, e.data});
          check("out_last", {31'd0, bus.out_last}, {31'd0, e.last});
          check("in_ready_during_emit", {31'd0, bus.in_ready}, 32'd0);
          if (e.last) frames_done++;
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
    end
  end

  task automatic set_frame(input logic [63:0] p);
    for (int k = 0; k < N; k++) frame[k] = p[63-8*k -: 8];
  endtask

  task automatic load_frame(input bit junk);
    for (int k = 0; k < N; k++) begin
      int tries = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = frame[k];
      @(negedge clk);
      while (!bus.in_ready && tries < 200) begin
        @(negedge clk);
        tries++;
      end
      if (tries >= 200) check("load_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
    end
    check("in_ready_after_load", {31'd0, bus.in_ready}, 32'd0);
    check("busy_after_load", {31'd0, busy}, 32'd1);
    bus.in_valid = junk;
    bus.in_data  = W'($urandom);
  endtask

  task automatic wait_frame(input bit junk, input bit bp, input bit rnd, input int target);
    int cyc = 0;
    int bp_left = 0;
    bit bp_armed = bp;
    while (frames_done < target && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (junk) begin
        bus.in_valid = busy;
        bus.in_data  = W'($urandom);
      end
      if (bp_left > 0) begin
        bus.out_ready = 1'b0;
        bp_left--;
      end else if (bp_armed && bus.out_valid && bus.out_data == 8'd1) begin
        bus.out_ready = 1'b0;
        bp_left  = 4;
        bp_armed = 1'b0;
      end else if (rnd) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.out_ready = 1'b1;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    if (frames_done < target) begin
      check("frame_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    check("in_ready_after_frame", {31'd0, bus.in_ready}, 32'd1);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    check("out_valid_after_frame", {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic run_frame(input logic [63:0] p, input bit junk, input bit bp, input bit rnd);
    int target;
    set_frame(p);
    target = frames_done + 1;
    load_frame(junk);
    model_push();
    wait_frame(junk, bp, rnd, target);
    check("unique_cnt", {28'd0, unique_cnt}, exp_unique);
    check("dup_cnt", {28'd0, dup_cnt}, exp_dup);
`ifdef DEDUP_STATS_EN
    check("scan_cycles", {16'd0, scan_cycles}, exp_scan);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_out_data"}, {24'd0, bus.out_data}, 32'd0);
    check({tag, "_out_last"}, {31'd0, bus.out_last}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_unique_cnt"}, {28'd0, unique_cnt}, 32'd0);
    check({tag, "_dup_cnt"}, {28'd0, dup_cnt}, 32'd0);
`ifdef DEDUP_STATS_EN
    check({tag, "_scan_cycles"}, {16'd0, scan_cycles}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Mixed duplicates, then all distinct, then all equal.
    run_frame({8'd3, 8'd1, 8'd3, 8'd7, 8'd1, 8'd1, 8'd9, 8'd3}, 1'b0, 1'b0, 1'b0);
    run_frame({8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7}, 1'b0, 1'b0, 1'b0);
    run_frame({8{8'hAA}}, 1'b0, 1'b0, 1'b0);

    // Backpressure on element 1 for five cycles.
    stall_seen = 0;
    run_frame({8'd3, 8'd1, 8'd3, 8'd7, 8'd1, 8'd1, 8'd9, 8'd3}, 1'b0, 1'b1, 1'b0);
    check("stall_cycles_on_1", stall_seen, 32'd5);

    // Asynchronous reset in the middle of SCAN discards the frame.
    set_frame({8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17});
    load_frame(1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_values("midscan_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame({8'd5, 8'd5, 8'd6, 8'd6, 8'd7, 8'd7, 8'd8, 8'd8}, 1'b0, 1'b0, 1'b0);

    // in_valid held high with changing data during SCAN/EMIT, then a clean frame.
    run_frame({8'd2, 8'd4, 8'd2, 8'd8, 8'd4, 8'd16, 8'd2, 8'd32}, 1'b1, 1'b0, 1'b0);
    run_frame({8'd9, 8'd8, 8'd9, 8'd8, 8'd9, 8'd8, 8'd9, 8'd8}, 1'b0, 1'b0, 1'b0);

    // Randomised frames with small value ranges and random consumer stalls.
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N; k++) p[63-8*k -: 8] = 8'($urandom_range(0, 4));
      run_frame(p, f[0], 1'b0, 1'b1);
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
